// File: rtl/axi_lite_sram_slv_if.sv
// axi_lite_sram_slv_if: AXI-lite bus between a master and the SRAM responder
interface axi_lite_sram_slv_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              slv_ar_valid_i;
  logic [ADDR_W-1:0] slv_ar_addr_i;
  logic              slv_ar_ready_o;
  logic              slv_r_valid_o;
  logic [DATA_W-1:0] slv_r_data_o;
  logic [1:0]        slv_r_resp_o;
  logic              slv_r_ready_i;
  logic              slv_aw_valid_i;
  logic [ADDR_W-1:0] slv_aw_addr_i;
  logic              slv_aw_ready_o;
  logic              slv_w_valid_i;
  logic [DATA_W-1:0] slv_w_data_i;
  logic [DATA_W/8-1:0] slv_w_strb_i;
  logic              slv_w_ready_o;
  logic              slv_b_valid_o;
  logic [1:0]        slv_b_resp_o;
  logic              slv_b_ready_i;
  modport slave (
    input  slv_ar_valid_i, slv_ar_addr_i, slv_r_ready_i,
    input  slv_aw_valid_i, slv_aw_addr_i, slv_w_valid_i, slv_w_data_i, slv_w_strb_i, slv_b_ready_i,
    output slv_ar_ready_o, slv_r_valid_o, slv_r_data_o, slv_r_resp_o,
    output slv_aw_ready_o, slv_w_ready_o, slv_b_valid_o, slv_b_resp_o
  );
  modport master (
    output slv_ar_valid_i, slv_ar_addr_i, slv_r_ready_i,
    output slv_aw_valid_i, slv_aw_addr_i, slv_w_valid_i, slv_w_data_i, slv_w_strb_i, slv_b_ready_i,
    input  slv_ar_ready_o, slv_r_valid_o, slv_r_data_o, slv_r_resp_o,
    input  slv_aw_ready_o, slv_w_ready_o, slv_b_valid_o, slv_b_resp_o
  );
endinterface

// File: rtl/axi_lite_sram_slv.sv
// axi_lite_sram_slv: single-outstanding AXI-lite responder over a word SRAM with programmable latency
module axi_lite_sram_slv #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input logic clk_i,
  input logic rst_i,
  axi_lite_sram_slv_if.slave s
);
  localparam int SB = DATA_W / 8;
  localparam int SH = $clog2(SB);
  localparam int IW = $clog2(DEPTH);
  localparam int LM = RD_LAT > WR_LAT ? RD_LAT : WR_LAT;
  localparam int CW = $clog2(LM) > 0 ? $clog2(LM) : 1;
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    R_WAIT = 5'b00010,
    R_RSP  = 5'b00100,
    W_WAIT = 5'b01000,
    B_RSP  = 5'b10000
  } state_t;
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic r_aw_got, r_w_got, w_aw_nx, w_w_nx, r_up;
  logic [ADDR_W-1:0] r_addr, w_off;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [SB-1:0] r_wstrb;
  logic [1:0] r_rresp, r_bresp;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic w_idle, w_ar_ready, w_aw_ready, w_w_ready, w_ar_hs, w_aw_hs, w_w_hs;
  logic w_oor, w_done, w_commit;
  logic [IW-1:0] w_idx;
  // r_up keeps every ready low until the first edge after reset release
  assign w_idle     = r_up & (r_state == IDLE);
  assign w_ar_ready = w_idle & !r_aw_got & !r_w_got;
  assign w_ar_hs    = w_ar_ready & s.slv_ar_valid_i;
  assign w_aw_ready = w_idle & !r_aw_got & !w_ar_hs;
  assign w_w_ready  = w_idle & !r_w_got & !w_ar_hs;
  assign w_aw_hs    = w_aw_ready & s.slv_aw_valid_i;
  assign w_w_hs     = w_w_ready & s.slv_w_valid_i;
  assign w_off      = r_addr - BASE_ADDR;
  assign w_idx      = w_off[SH +: IW];
  assign w_oor      = (r_addr < BASE_ADDR) | ((w_off >> SH) >= ADDR_W'(DEPTH));
  assign w_done     = r_cnt == '0;
  assign w_commit   = (r_state == W_WAIT) & w_done & !w_oor;
  assign s.slv_ar_ready_o = w_ar_ready;
  assign s.slv_aw_ready_o = w_aw_ready;
  assign s.slv_w_ready_o  = w_w_ready;
  assign s.slv_r_valid_o  = r_state == R_RSP;
  assign s.slv_r_data_o   = r_rdata;
  assign s.slv_r_resp_o   = r_rresp;
  assign s.slv_b_valid_o  = r_state == B_RSP;
  assign s.slv_b_resp_o   = r_bresp;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_aw_nx    = r_aw_got | w_aw_hs;
    w_w_nx     = r_w_got | w_w_hs;
    case (r_state)
      IDLE: begin
        w_state_nx = w_ar_hs ? R_WAIT : (w_aw_nx & w_w_nx) ? W_WAIT : IDLE;
        w_cnt_nx   = w_ar_hs ? CW'(RD_LAT - 1) : (w_aw_nx & w_w_nx) ? CW'(WR_LAT - 1) : r_cnt;
      end
      R_WAIT, W_WAIT: begin
        w_cnt_nx   = w_done ? r_cnt : r_cnt - CW'(1);
        w_state_nx = !w_done ? r_state : (r_state == R_WAIT) ? R_RSP : B_RSP;
      end
      R_RSP, B_RSP: begin
        if ((r_state == R_RSP & s.slv_r_ready_i) | (r_state == B_RSP & s.slv_b_ready_i)) begin
          w_state_nx = IDLE;
          w_aw_nx    = 1'b0;
          w_w_nx     = 1'b0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_up     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_bresp  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_aw_got <= w_aw_nx;
      r_w_got  <= w_w_nx;
      r_up     <= 1'b1;
      if (w_ar_hs | w_aw_hs) r_addr <= w_ar_hs ? s.slv_ar_addr_i : s.slv_aw_addr_i;
      if (w_w_hs) begin
        r_wdata <= s.slv_w_data_i;
        r_wstrb <= s.slv_w_strb_i;
      end
      if (r_state == R_WAIT && w_done) begin
        r_rdata <= w_oor ? '0 : r_mem[w_idx];
        r_rresp <= w_oor ? 2'b11 : 2'b00;
      end
      if (r_state == W_WAIT && w_done) r_bresp <= w_oor ? 2'b11 : 2'b00;
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < SB; i++)
      if (w_commit && r_wstrb[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_axi_lite_sram_slv.sv
// tb_axi_lite_sram_slv: directed scoreboard bench for the AXI-lite SRAM responder
module tb_axi_lite_sram_slv;
  localparam int RL = 3;
  localparam int WL = 4;
  localparam int DP = 4096;
  localparam logic [31:0] BA = 32'h8000_0000;
  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;
  rexp_t rq[$];
  logic [1:0] bq[$];
  logic [31:0] mdl [int];
  axi_lite_sram_slv_if #(.ADDR_W(32), .DATA_W(32)) s ();
  axi_lite_sram_slv #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DP), .BASE_ADDR(BA), .RD_LAT(RL), .WR_LAT(WL)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .s(s)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit inr(input logic [31:0] a);
    return a >= BA && ((a - BA) >> 2) < DP;
  endfunction
  task automatic mwr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    logic [31:0] w;
    int k;
    if (inr(a)) begin
      k = int'((a - BA) >> 2);
      w = mdl.exists(k) ? mdl[k] : 32'hx;
      for (int i = 0; i < 4; i++) if (st[i]) w[8*i +: 8] = d[8*i +: 8];
      mdl[k] = w;
    end
    bq.push_back(inr(a) ? 2'b00 : 2'b11);
  endtask
  task automatic rexp(input logic [31:0] a);
    rexp_t e;
    e.d = 32'h0;
    e.r = 2'b11;
    if (inr(a)) begin
      e.d = mdl[int'((a - BA) >> 2)];
      e.r = 2'b00;
    end
    rq.push_back(e);
  endtask
  task automatic ar_send(input logic [31:0] a, output int t);
    int n = 0;
    s.slv_ar_valid_i = 1'b1;
    s.slv_ar_addr_i  = a;
    #1;
    while (!s.slv_ar_ready_o && n < 50) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk("ar_ready", s.slv_ar_ready_o, 1);
    @(negedge clk_i);
    t = cyc;
    s.slv_ar_valid_i = 1'b0;
  endtask
  task automatic r_take(input int t, input int hold);
    int n = 0;
    rexp_t e;
    while (!s.slv_r_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("r_latency", cyc - t, RL);
    e = rq.pop_front();
    chk("r_data", s.slv_r_data_o, e.d);
    chk("r_resp", s.slv_r_resp_o, e.r);
    repeat (hold) begin
      @(negedge clk_i);
      chk("r_hold_valid", s.slv_r_valid_o, 1);
      chk("r_hold_data", s.slv_r_data_o, e.d);
    end
    s.slv_r_ready_i = 1'b1;
    @(negedge clk_i);
    s.slv_r_ready_i = 1'b0;
    chk("r_drop", s.slv_r_valid_o, 0);
  endtask
  task automatic wr_send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                         input int da, input int dw, output int t);
    bit ad = 0, wd = 0, ha, hw;
    int k = 0, ta = 0, tw = 0;
    while (!(ad && wd) && k < 60) begin
      s.slv_aw_valid_i = !ad && k >= da;
      s.slv_aw_addr_i  = a;
      s.slv_w_valid_i  = !wd && k >= dw;
      s.slv_w_data_i   = d;
      s.slv_w_strb_i   = st;
      #1;
      ha = s.slv_aw_valid_i && s.slv_aw_ready_o;
      hw = s.slv_w_valid_i && s.slv_w_ready_o;
      @(negedge clk_i);
      k++;
      if (ha) begin ad = 1; ta = cyc; end
      if (hw) begin wd = 1; tw = cyc; end
    end
    s.slv_aw_valid_i = 1'b0;
    s.slv_w_valid_i  = 1'b0;
    chk("wr_handshakes", {ad, wd}, 2'b11);
    t = ta > tw ? ta : tw;
  endtask
  task automatic b_take(input int t);
    int n = 0;
    logic [1:0] e;
    while (!s.slv_b_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("b_latency", cyc - t, WL);
    e = bq.pop_front();
    chk("b_resp", s.slv_b_resp_o, e);
    s.slv_b_ready_i = 1'b1;
    @(negedge clk_i);
    s.slv_b_ready_i = 1'b0;
    chk("b_drop", s.slv_b_valid_o, 0);
  endtask
  task automatic rd(input logic [31:0] a, input int hold);
    int t;
    rexp(a);
    ar_send(a, t);
    r_take(t, hold);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                    input int da, input int dw);
    int t;
    mwr(a, d, st);
    wr_send(a, d, st, da, dw, t);
    b_take(t);
  endtask
  initial begin
    int t, tr, tw, ta;
    s.slv_ar_valid_i = 0; s.slv_ar_addr_i = 0; s.slv_r_ready_i = 0;
    s.slv_aw_valid_i = 0; s.slv_aw_addr_i = 0; s.slv_w_valid_i = 0;
    s.slv_w_data_i = 0; s.slv_w_strb_i = 0; s.slv_b_ready_i = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_ar_ready", s.slv_ar_ready_o, 0);
    chk("rst_aw_ready", s.slv_aw_ready_o, 0);
    chk("rst_w_ready", s.slv_w_ready_o, 0);
    chk("rst_r_valid", s.slv_r_valid_o, 0);
    chk("rst_b_valid", s.slv_b_valid_o, 0);
    chk("rst_r_data", s.slv_r_data_o, 0);
    chk("rst_r_resp", s.slv_r_resp_o, 0);
    chk("rst_b_resp", s.slv_b_resp_o, 0);
    rst_i = 1'b1;
    #1;
    chk("ready_before_edge", s.slv_ar_ready_o, 0);
    @(negedge clk_i);
    chk("ar_ready_up", s.slv_ar_ready_o, 1);
    chk("aw_ready_up", s.slv_aw_ready_o, 1);
    chk("w_ready_up", s.slv_w_ready_o, 1);
    // read latency and hold
    wr(BA, 32'hDEAD_BEEF, 4'hF, 0, 0);
    rd(BA, 5);
    // partial strobes
    wr(BA + 4, 32'h1122_3344, 4'hF, 0, 0);
    wr(BA + 4, 32'hAABB_CCDD, 4'b0101, 0, 0);
    rd(BA + 4, 0);
    // W two cycles ahead of AW, then both together
    wr(BA + 8, 32'h5566_7788, 4'hF, 2, 0);
    wr(BA + 12, 32'h99AA_BBCC, 4'hF, 0, 0);
    rd(BA + 8, 0);
    rd(BA + 12, 0);
    // simultaneous AR and AW/W: read wins, write follows right after R
    rexp(BA + 8);
    mwr(BA + 16, 32'h0BAD_F00D, 4'hF);
    s.slv_ar_valid_i = 1; s.slv_ar_addr_i = BA + 8;
    s.slv_aw_valid_i = 1; s.slv_aw_addr_i = BA + 16;
    s.slv_w_valid_i = 1; s.slv_w_data_i = 32'h0BAD_F00D; s.slv_w_strb_i = 4'hF;
    #1;
    chk("prio_ar_ready", s.slv_ar_ready_o, 1);
    chk("prio_aw_ready", s.slv_aw_ready_o, 0);
    chk("prio_w_ready", s.slv_w_ready_o, 0);
    @(negedge clk_i);
    t = cyc;
    s.slv_ar_valid_i = 0;
    chk("aw_blocked_in_read", s.slv_aw_ready_o, 0);
    r_take(t, 0);
    tr = cyc;
    #1;
    chk("aw_ready_after_r", s.slv_aw_ready_o, 1);
    chk("w_ready_after_r", s.slv_w_ready_o, 1);
    @(negedge clk_i);
    tw = cyc;
    s.slv_aw_valid_i = 0;
    s.slv_w_valid_i = 0;
    chk("back_to_back", tw - tr, 1);
    b_take(tw);
    rd(BA + 16, 0);
    // AW captured first blocks AR until B completes
    mwr(BA + 20, 32'h1357_9BDF, 4'hF);
    s.slv_aw_valid_i = 1; s.slv_aw_addr_i = BA + 20;
    #1;
    chk("aw_only_ready", s.slv_aw_ready_o, 1);
    @(negedge clk_i);
    s.slv_aw_valid_i = 0;
    s.slv_ar_valid_i = 1; s.slv_ar_addr_i = BA;
    #1;
    repeat (3) begin
      chk("ar_blocked", s.slv_ar_ready_o, 0);
      @(negedge clk_i);
      #1;
    end
    s.slv_w_valid_i = 1; s.slv_w_data_i = 32'h1357_9BDF; s.slv_w_strb_i = 4'hF;
    #1;
    chk("w_ready_pending_aw", s.slv_w_ready_o, 1);
    @(negedge clk_i);
    tw = cyc;
    s.slv_w_valid_i = 0;
    chk("ar_blocked_in_write", s.slv_ar_ready_o, 0);
    b_take(tw);
    rexp(BA);
    #1;
    chk("ar_ready_after_b", s.slv_ar_ready_o, 1);
    @(negedge clk_i);
    ta = cyc;
    s.slv_ar_valid_i = 0;
    r_take(ta, 0);
    rd(BA + 20, 0);
    // decode errors and the last valid word
    rd(32'h7FFF_FFFC, 0);
    wr(BA + 4 * DP, 32'hFFFF_FFFF, 4'hF, 0, 0);
    rd(BA, 0);
    wr(BA + 4 * (DP - 1), 32'h2468_ACE0, 4'hF, 0, 0);
    rd(BA + 4 * (DP - 1), 0);
    // reset two cycles into a write's latency aborts it
    wr_send(BA + 4, 32'h0, 4'hF, 0, 0, t);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("midrst_ar_ready", s.slv_ar_ready_o, 0);
    chk("midrst_aw_ready", s.slv_aw_ready_o, 0);
    chk("midrst_w_ready", s.slv_w_ready_o, 0);
    chk("midrst_r_valid", s.slv_r_valid_o, 0);
    chk("midrst_b_valid", s.slv_b_valid_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("idle_after_rst", s.slv_ar_ready_o, 1);
    chk("no_b_after_rst", s.slv_b_valid_o, 0);
    rd(BA + 4, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
